addsub_pipe: RTL and testbench
==============================

// Module: addsub_pipe
// PURPOSE
//   Pipelined, parametrised add/subtract unit with status flags and valid/ready handshakes.
//   Successor to the combinational subtractor: adds add/sub mode select, STAGES-deep elastic
//   pipeline, a sticky overflow register and optional saturation. Sits between operand
//   sources and the datapath write-back; flags travel with their result.
// PARAMETERS
//   WIDTH   8  operand/result width in bits (>=2)
//   STAGES  2  pipeline register stages, 1..4; zero-stall latency = STAGES cycles
// PORTS
//   clk            in   1      clock, rising edge
//   rst            in   1      asynchronous, active-high reset
//   in_valid       in   1      operand beat valid
//   in_ready       out  1      unit can accept a beat this cycle
//   a, b           in   WIDTH  operands
//   cin            in   1      carry in (1 = true subtract / +1 on add)
//   sub_en         in   1      1: a + ~b + cin ; 0: a + b + cin
//   signed_en      in   1      1: two's-complement flag rules ; 0: unsigned
//   out_valid      out  1      result beat valid
//   out_ready      in   1      consumer accepts result
//   final_out      out  WIDTH  result
//   cout           out  1      carry out of bit WIDTH-1 (sub: 1 = no borrow)
//   zero_flag      out  1      final_out == 0
//   negative_flag  out  1      signed_en ? final_out[WIDTH-1] : 0
//   overflow_flag  out  1      signed: sign overflow; unsigned: add cout / sub ~cout
//   clr_sticky     in   1      clear sticky_ovf
//   sticky_ovf     out  1      set by any accepted result beat with overflow_flag=1
// BEHAVIOUR
//   - Reset: all stage valids 0, data/flag regs 0, out_valid 0, sticky_ovf 0, in_ready 0
//     while rst high; in-flight beats discarded, none emitted after release.
//   - Handshake: beat transfers on valid&&ready. Producer holds a/b/cin/mode stable
//     while in_valid && !in_ready. out_valid/final_out/flags hold stable until out_ready.
//   - Elastic pipeline: stage i loads when empty or when stage i+1 loads this cycle;
//     last stage unloads on out_ready. in_ready = stage 0 loadable (combinational,
//     may depend on out_ready). Full throughput 1 beat/cycle; no bubbles inserted.
//   - Order preserved; no beat lost or duplicated under any stall pattern.
//   - Arithmetic in stage 0 on WIDTH+1 bits; flags computed from the WIDTH-bit result
//     (after saturation when enabled); later stages carry result+flags unchanged.
//   - Signed overflow: operands (a, sub_en ? ~b : b) same sign, result sign differs.
//   - Wrap-around: without saturation result is sum modulo 2^WIDTH.
//   - Sticky: set on output handshake with overflow_flag; clr_sticky clears; set and
//     clear in same cycle -> sticky_ovf = 1.
// CONFIGURATION
//   ADDSUB_SAT_EN defined: on overflow_flag, final_out clamps — signed: 2^(W-1)-1 if
//     true sum positive else -2^(W-1); unsigned add: all ones; unsigned sub: 0.
//     overflow_flag still reports 1; cout reports raw carry.
//   Not defined: no clamp logic synthesised, result always wraps.
// STRUCTURE
//   Package addsub_pkg: flag bit-index localparams (Z,N,V,C), STAGES min/max limits,
//     saturation max/min value functions of WIDTH.
//   Sub-module addsub_core: combinational sum, flags, optional clamp; one instance in
//     stage 0. Top holds stage registers, valid chain, handshake and sticky logic.
// TESTING (WIDTH=8, STAGES=2)
//   1. a=5,b=3,cin=1,sub,unsigned -> 2 cycles later final_out=2, cout=1, z=0 n=0 v=0.
//   2. a=3,b=5,cin=1,sub,unsigned -> final_out=0xFE, cout=0, v=1, n=0; sticky_ovf=1.
//   3. a=-10,b=20,cin=1,sub,signed -> final_out=0xE2 (-30), n=1, v=0, cout=1.
//   4. a=127,b=-1,cin=1,sub,signed -> 0x80 v=1 n=1; with ADDSUB_SAT_EN 0x7F v=1 n=0.
//   5. out_ready=0 for 5 cycles, in_valid=1 streaming -> in_ready falls after 2 beats
//      held; on release beats emerge in order, one per cycle, none lost/duplicated.
//   6. rst pulse with 2 beats in flight, plus clr_sticky coincident with overflow beat
//      -> out_valid=0 and sticky_ovf=0 immediately on rst; coincident case sticky=1.

Source files
------------

// File: rtl/addsub_pkg.sv
// Shared definitions for the addsub_pipe slice: flag bit positions, legal
// pipeline depth range and saturation limit helpers.
package addsub_pkg;

  localparam int unsigned FLAG_Z    = 0;
  localparam int unsigned FLAG_N    = 1;
  localparam int unsigned FLAG_V    = 2;
  localparam int unsigned FLAG_C    = 3;
  localparam int unsigned NUM_FLAGS = 4;

  localparam int unsigned STAGES_MIN = 1;
  localparam int unsigned STAGES_MAX = 4;

  // Largest positive two's-complement value for a w-bit word.
  function automatic logic [63:0] sat_smax(input int unsigned w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  // Most negative two's-complement value for a w-bit word.
  function automatic logic [63:0] sat_smin(input int unsigned w);
    return 64'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/addsub_pipe_if.sv
// Operand/result handshake bundle for addsub_pipe.
// master: operand producer + result consumer; slave: the arithmetic unit.
interface addsub_pipe_if #(parameter int unsigned WIDTH = 8);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub_en;
  logic             signed_en;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] final_out;
  logic             cout;
  logic             zero_flag;
  logic             negative_flag;
  logic             overflow_flag;

  modport master (
    output in_valid, a, b, cin, sub_en, signed_en, out_ready,
    input  in_ready, out_valid, final_out, cout, zero_flag, negative_flag, overflow_flag
  );

  modport slave (
    input  in_valid, a, b, cin, sub_en, signed_en, out_ready,
    output in_ready, out_valid, final_out, cout, zero_flag, negative_flag, overflow_flag
  );

endinterface

// File: rtl/addsub_core.sv
// Combinational add/subtract with Z/N/V/C flags.
// Optional clamp on overflow when ADDSUB_SAT_EN is defined.
module addsub_core
  import addsub_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 a_sign_unused_guard,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 cin,
  input  logic                 sub_en,
  input  logic                 signed_en,
  output logic [WIDTH-1:0]     result,
  output logic [NUM_FLAGS-1:0] flags
);

`ifdef ADDSUB_SAT_EN
  localparam logic [WIDTH-1:0] SMAX = WIDTH'(sat_smax(WIDTH));
  localparam logic [WIDTH-1:0] SMIN = WIDTH'(sat_smin(WIDTH));
`endif

  logic [WIDTH-1:0] bx;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] raw;
  logic             carry;
  logic             ovf;
  logic             guard_unused;

  // Sum on WIDTH+1 bits, overflow detection, optional clamp, then flags.
  always_comb begin
    guard_unused = a_sign_unused_guard;
    bx     = sub_en ? ~b : b;
    sum    = {1'b0, a} + {1'b0, bx} + {{WIDTH{1'b0}}, cin};
    raw    = sum[WIDTH-1:0];
    carry  = sum[WIDTH];
    if (signed_en)
      ovf = (a[WIDTH-1] == bx[WIDTH-1]) && (raw[WIDTH-1] != a[WIDTH-1]);
    else
      ovf = sub_en ? ~carry : carry;
    result = raw;
`ifdef ADDSUB_SAT_EN
    if (ovf) begin
      if (signed_en)
        result = a[WIDTH-1] ? SMIN : SMAX;
      else
        result = sub_en ? '0 : '1;
    end
`endif
    flags         = '0;
    flags[FLAG_Z] = (result == '0);
    flags[FLAG_N] = signed_en & result[WIDTH-1];
    flags[FLAG_V] = ovf;
    flags[FLAG_C] = carry;
  end

endmodule

// File: rtl/addsub_pipe.sv
// Elastic STAGES-deep add/subtract pipeline with flags and sticky overflow.
// Optional feature macro: ADDSUB_SAT_EN (saturate result on overflow).
module addsub_pipe
  import addsub_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  addsub_pipe_if.slave bus,
  input  logic         clr_sticky,
  output logic         sticky_ovf
);

  if (STAGES < STAGES_MIN || STAGES > STAGES_MAX) begin : g_bad_stages
    $error("addsub_pipe: STAGES out of range");
  end

  logic [WIDTH-1:0]     core_res;
  logic [NUM_FLAGS-1:0] core_flags;
  logic [WIDTH-1:0]     res_q   [STAGES];
  logic [NUM_FLAGS-1:0] flags_q [STAGES];
  logic [STAGES-1:0]    vld_q;
  logic [STAGES-1:0]    load;

  addsub_core #(.WIDTH(WIDTH)) u_core (
    .a_sign_unused_guard (1'b0),
    .a                   (bus.a),
    .b                   (bus.b),
    .cin                 (bus.cin),
    .sub_en              (bus.sub_en),
    .signed_en           (bus.signed_en),
    .result              (core_res),
    .flags               (core_flags)
  );

  // Stage i can load when out_ready or any stage at or after i is empty;
  // flattened from the recursive form to avoid a self-dependent vector.
  always_comb begin
    load = '0;
    for (int unsigned i = 0; i < STAGES; i++) begin
      load[i] = bus.out_ready;
      for (int unsigned j = i; j < STAGES; j++)
        load[i] = load[i] | ~vld_q[j];
    end
  end

  // Pipeline registers: stage 0 captures the core, later stages shift.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      for (int unsigned i = 0; i < STAGES; i++) begin
        res_q[i]   <= '0;
        flags_q[i] <= '0;
      end
    end else begin
      if (load[0]) begin
        vld_q[0]   <= bus.in_valid;
        res_q[0]   <= core_res;
        flags_q[0] <= core_flags;
      end
      for (int unsigned i = 1; i < STAGES; i++) begin
        if (load[i]) begin
          vld_q[i]   <= vld_q[i-1];
          res_q[i]   <= res_q[i-1];
          flags_q[i] <= flags_q[i-1];
        end
      end
    end
  end

  // Handshake and result outputs from the last stage.
  always_comb begin
    bus.in_ready      = load[0] & ~rst;
    bus.out_valid     = vld_q[STAGES-1];
    bus.final_out     = res_q[STAGES-1];
    bus.zero_flag     = flags_q[STAGES-1][FLAG_Z];
    bus.negative_flag = flags_q[STAGES-1][FLAG_N];
    bus.overflow_flag = flags_q[STAGES-1][FLAG_V];
    bus.cout          = flags_q[STAGES-1][FLAG_C];
  end

  // Sticky overflow: set wins over a coincident clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      sticky_ovf <= 1'b0;
    else
      sticky_ovf <= (sticky_ovf & ~clr_sticky) |
                    (bus.out_valid & bus.out_ready & bus.overflow_flag);
  end

endmodule

// File: tb/tb_addsub_pipe.sv
// Directed self-checking bench for addsub_pipe (WIDTH=8, STAGES=2).
// Honours ADDSUB_SAT_EN for the saturating expectations.
module tb_addsub_pipe;

  localparam int unsigned W = 8;

`ifdef ADDSUB_SAT_EN
  localparam logic [7:0] T2_RES = 8'h00;
  localparam logic       T2_Z   = 1'b1;
  localparam logic [7:0] T4_RES = 8'h7F;
  localparam logic       T4_N   = 1'b0;
  localparam logic [7:0] UA_RES = 8'hFF;
`else
  localparam logic [7:0] T2_RES = 8'hFE;
  localparam logic       T2_Z   = 1'b0;
  localparam logic [7:0] T4_RES = 8'h80;
  localparam logic       T4_N   = 1'b1;
  localparam logic [7:0] UA_RES = 8'h10;
`endif

  logic clk = 1'b0;
  logic rst;
  logic clr_sticky;
  logic sticky_ovf;
  int   n_checks = 0;
  int   n_err    = 0;
  int   next_in;
  int   next_out;

  addsub_pipe_if #(.WIDTH(W)) bus ();

  addsub_pipe #(.WIDTH(W), .STAGES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .clr_sticky (clr_sticky),
    .sticky_ovf (sticky_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One beat with out_ready=1; checks exact 2-cycle latency and all outputs.
  task automatic run_vec(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic cin, input logic sub, input logic sgn,
                         input logic [7:0] e_res, input logic e_c, input logic e_z,
                         input logic e_n, input logic e_v);
    @(negedge clk);
    bus.a = a; bus.b = b; bus.cin = cin; bus.sub_en = sub; bus.signed_en = sgn;
    bus.in_valid = 1'b1;
    #1 chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(negedge clk);
    chk({tag, "_early"}, 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    chk({tag, "_res"},   32'(bus.final_out), 32'(e_res));
    chk({tag, "_cout"},  32'(bus.cout), 32'(e_c));
    chk({tag, "_z"},     32'(bus.zero_flag), 32'(e_z));
    chk({tag, "_n"},     32'(bus.negative_flag), 32'(e_n));
    chk({tag, "_v"},     32'(bus.overflow_flag), 32'(e_v));
  endtask

  initial begin
    rst = 1'b1; clr_sticky = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.sub_en = 1'b0; bus.signed_en = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready",  32'(bus.in_ready), 32'd0);
    chk("rst_sticky",    32'(sticky_ovf), 32'd0);
    chk("rst_final_out", 32'(bus.final_out), 32'd0);
    rst = 1'b0;

    run_vec("t1", 8'd5, 8'd3, 1'b1, 1'b1, 1'b0, 8'h02, 1'b1, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1 chk("t1_sticky", 32'(sticky_ovf), 32'd0);

    run_vec("t2", 8'd3, 8'd5, 1'b1, 1'b1, 1'b0, T2_RES, 1'b0, T2_Z, 1'b0, 1'b1);
    @(posedge clk); #1 chk("t2_sticky", 32'(sticky_ovf), 32'd1);
    @(negedge clk); clr_sticky = 1'b1;
    @(posedge clk); #1 clr_sticky = 1'b0;
    chk("clr_sticky", 32'(sticky_ovf), 32'd0);

    run_vec("t3", 8'hF6, 8'h14, 1'b1, 1'b1, 1'b1, 8'hE2, 1'b1, 1'b0, 1'b1, 1'b0);
    run_vec("zero", 8'd7, 8'd7, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    run_vec("uadd_ovf", 8'hF0, 8'h20, 1'b0, 1'b0, 1'b0, UA_RES, 1'b1, 1'b0, 1'b0, 1'b1);
    run_vec("t4", 8'h7F, 8'hFF, 1'b1, 1'b1, 1'b1, T4_RES, 1'b0, 1'b0, T4_N, 1'b1);

    // Stall the consumer while the producer streams.
    next_in = 0; next_out = 0;
    @(negedge clk);
    bus.out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (c > 0) @(negedge clk);
      bus.in_valid = 1'b1; bus.a = 8'(next_in); bus.b = '0;
      bus.cin = 1'b0; bus.sub_en = 1'b0; bus.signed_en = 1'b0;
      #1 if (bus.in_ready) next_in++;
    end
    chk("stall_accepted", 32'(next_in), 32'd2);
    chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
    chk("stall_hold", 32'(bus.final_out), 32'd0);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      bus.out_ready = 1'b1;
      bus.in_valid  = (next_in < 8);
      bus.a         = 8'(next_in);
      #1;
      chk("stream_ov", 32'(bus.out_valid), (c < 8) ? 32'd1 : 32'd0);
      if (bus.out_valid) begin
        chk("stream_data", 32'(bus.final_out), 32'(next_out));
        next_out++;
      end
      if (bus.in_valid && bus.in_ready) next_in++;
    end
    bus.in_valid = 1'b0;
    chk("stream_in_count",  32'(next_in), 32'd8);
    chk("stream_out_count", 32'(next_out), 32'd8);

    // Reset with two beats stalled in flight.
    chk("pre_rst_sticky", 32'(sticky_ovf), 32'd1);
    bus.out_ready = 1'b0;
    repeat (2) begin
      @(negedge clk);
      bus.in_valid = 1'b1; bus.a = 8'h11;
      @(posedge clk); #1 bus.in_valid = 1'b0;
    end
    @(negedge clk);
    chk("inflight_valid", 32'(bus.out_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("async_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("async_rst_sticky",    32'(sticky_ovf), 32'd0);
    chk("async_rst_in_ready",  32'(bus.in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0; bus.out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("post_rst_no_beat", 32'(bus.out_valid), 32'd0);
    end

    // Overflow beat at the output coincident with a clear request.
    run_vec("coinc", 8'd3, 8'd5, 1'b1, 1'b1, 1'b0, T2_RES, 1'b0, T2_Z, 1'b0, 1'b1);
    clr_sticky = 1'b1;
    @(posedge clk); #1 clr_sticky = 1'b0;
    chk("coinc_sticky", 32'(sticky_ovf), 32'd1);
    @(negedge clk); clr_sticky = 1'b1;
    @(posedge clk); #1 clr_sticky = 1'b0;
    chk("coinc_clear", 32'(sticky_ovf), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
